serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle, parametrised N-bit subtractor computing diff = a - b - bin.
//   Built as a chain of DIGIT full-subtractor cells, reused LSB-first over
//   WIDTH/DIGIT cycles with a registered borrow.
//   Trades latency for area. Has a start/busy/done handshake so a controller
//   or datapath sequencer can drive it. Also flags unsigned borrow and
//   two's-complement signed overflow.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 1
//   DIGIT  1  bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise)
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only when not busy
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   bin     in   1      borrow-in, captured on accepted start
//   busy    out  1      1 while a subtraction is in progress
//   done    out  1      one-cycle pulse: results valid this cycle
//   diff    out  WIDTH  result a - b - bin, modulo 2^WIDTH
//   borrow  out  1      final borrow out of the MSB (1 = unsigned underflow)
//   ovf     out  1      signed overflow: sign(a) != sign(b) and sign(diff) != sign(a)
// BEHAVIOUR
//   Reset state: rst_n=0 forces IDLE; busy=0, done=0, diff=0, borrow=0, ovf=0.
//     Internal shift registers, counter and borrow register are cleared.
//   FSM states: IDLE, RUN, DONE. N = WIDTH/DIGIT.
//   IDLE: start=1 at an edge captures a, b and bin, sets cnt=0, and goes to RUN.
//     start=0 stays in IDLE.
//   RUN: each edge handles DIGIT bits.
//     - Low DIGIT bits of the a/b shift regs, plus the borrow reg, go through
//       the cell chain. Cell: d = x^y^c; bo = (~x&y) | (~(x^y)&c).
//     - The d bits shift into the result reg from the top.
//     - The borrow reg takes the chain's borrow out.
//     - cnt increments.
//     - On the edge with cnt == N-1, the final values go into diff, borrow and
//       ovf, and the FSM moves to DONE.
//   DONE: lasts one cycle with done=1 and busy=0. Then:
//     - start=1 at that edge is accepted (back-to-back, same as from IDLE) and
//       the FSM goes to RUN.
//     - otherwise the FSM goes to IDLE.
//   busy = (state == RUN); done = (state == DONE); both are registered decodes.
//   Latency: start sampled at edge E0 -> busy high for cycles 1..N -> done high
//     in cycle N+1. Throughput is one result per N+1 cycles.
//   Output hold: diff, borrow and ovf change only on the edge that enters DONE.
//     They hold their value through IDLE and any later RUN until the next
//     completion.
//   start while busy: ignored. Operands are not recaptured and there is no
//     error flag.
//   a, b and bin may change freely after the start edge; only the captured
//     copies are used.
//   Reset mid-RUN: aborts immediately and clears all outputs to 0. No done
//     pulse is produced.
//   Corner case: WIDTH == DIGIT gives N=1, so the result lands one edge after
//     start.
//   ovf uses captured a[WIDTH-1] and b[WIDTH-1] with the final diff[WIDTH-1].
//     It is valid for every bin value.
// TESTING
//   T1 W=8,D=1: a=0x5A, b=0x3C, bin=0 -> done in cycle 9;
//      diff=0x1E, borrow=0, ovf=0; busy high exactly cycles 1..8.
//   T2 W=8,D=1: a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow=1, ovf=0.
//      Then a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
//   T3 W=1,D=1: all 8 {a,b,bin} combos -> match the full-subtractor truth
//      table (e.g. 0,1,1 -> diff=0, borrow=1; 1,0,1 -> 0,0); done 1 edge
//      after start.
//   T4 W=8,D=4: a=0x10, b=0x01, bin=1 -> diff=0x0E, borrow=0 with done in
//      cycle 3.
//      Then start asserted in the done cycle with a=0x01, b=0x02 ->
//      diff=0xFF, borrow=1 three cycles later.
//   T5 W=8,D=1: start pulsed again in cycle 4 with different operands ->
//      ignored, and the first result is unchanged.
//      rst_n low in cycle 5 of a new op -> busy, done, diff, borrow and ovf
//      all 0 at once, and no done follows.
//   T6 W=16,D=2 random: 1000 ops checked against a reference {borrow,diff} =
//      {1'b0,a} - b - bin; ovf also checked; outputs stable between done
//      pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH/DIGIT cycles, LSB first,
// with a registered borrow between digits and a start/busy/done handshake.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int unsigned N     = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               brw_q, brw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               amsb_q, amsb_d;
   logic               bmsb_q, bmsb_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [DIGIT-1:0]   d_chain;
   logic               c_chain;
   logic [WIDTH-1:0]   res_sh;

   // Ripple of DIGIT full-subtractor cells fed by the low operand bits.
   always_comb begin
      d_chain = '0;
      c_chain = brw_q;
      for (int i = 0; i < int'(DIGIT); i++) begin
         d_chain[i] = a_q[i] ^ b_q[i] ^ c_chain;
         c_chain    = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c_chain);
      end
      res_sh = WIDTH'({d_chain, res_q} >> DIGIT);
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      brw_d    = brw_q;
      cnt_d    = cnt_q;
      amsb_d   = amsb_q;
      bmsb_d   = bmsb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               amsb_d  = a[WIDTH-1];
               bmsb_d  = b[WIDTH-1];
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            res_d = res_sh;
            brw_d = c_chain;
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(N - 1)) begin
               diff_d   = res_sh;
               borrow_d = c_chain;
               // Overflow only when operand signs differ and the result sign leaves a's.
               ovf_d    = (amsb_q ^ bmsb_q) & (res_sh[WIDTH-1] ^ amsb_q);
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
         amsb_q   <= 1'b0;
         bmsb_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         brw_q    <= brw_d;
         cnt_q    <= cnt_d;
         amsb_q   <= amsb_d;
         bmsb_q   <= bmsb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four parameterisations checked every cycle against
// an arithmetic latency model, plus directed literal expectations.
module tb_serial_subtractor;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] start_v = '0;
   logic [NI-1:0] bin_v   = '0;
   logic [15:0]   a_v [NI];
   logic [15:0]   b_v [NI];

   wire [NI-1:0] busy_w, done_w, bor_w, ovf_w;
   wire [7:0]    diff0;
   wire [0:0]    diff1;
   wire [7:0]    diff2;
   wire [15:0]   diff3;

   int n_tests = 0;
   int n_fail  = 0;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
      .bin(bin_v[0]), .busy(busy_w[0]), .done(done_w[0]), .diff(diff0),
      .borrow(bor_w[0]), .ovf(ovf_w[0]));
   serial_subtractor #(.WIDTH(1), .DIGIT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
      .bin(bin_v[1]), .busy(busy_w[1]), .done(done_w[1]), .diff(diff1),
      .borrow(bor_w[1]), .ovf(ovf_w[1]));
   serial_subtractor #(.WIDTH(8), .DIGIT(4)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][7:0]), .b(b_v[2][7:0]),
      .bin(bin_v[2]), .busy(busy_w[2]), .done(done_w[2]), .diff(diff2),
      .borrow(bor_w[2]), .ovf(ovf_w[2]));
   serial_subtractor #(.WIDTH(16), .DIGIT(2)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3]), .b(b_v[3]),
      .bin(bin_v[3]), .busy(busy_w[3]), .done(done_w[3]), .diff(diff3),
      .borrow(bor_w[3]), .ovf(ovf_w[3]));

   function automatic int w_of(int k);
      case (k)
         0: return 8;
         1: return 1;
         2: return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int n_of(int k);
      case (k)
         0: return 8;
         1: return 1;
         2: return 2;
         default: return 8;
      endcase
   endfunction

   function automatic logic [15:0] act_diff(int k);
      case (k)
         0: return 16'(diff0);
         1: return 16'(diff1);
         2: return 16'(diff2);
         default: return diff3;
      endcase
   endfunction

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Model: result = plain integer arithmetic, output appears N edges after the accepting edge.
   int          rem_m   [NI];
   logic        done_m  [NI];
   logic [15:0] diff_m  [NI];
   logic        bor_m   [NI];
   logic        ovf_m   [NI];
   logic [15:0] pdiff   [NI];
   logic        pbor    [NI];
   logic        povf    [NI];

   initial begin
      for (int k = 0; k < NI; k++) begin
         rem_m[k] = 0; done_m[k] = 1'b0; diff_m[k] = '0; bor_m[k] = 1'b0; ovf_m[k] = 1'b0;
         pdiff[k] = '0; pbor[k] = 1'b0; povf[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            rem_m[k] = 0; done_m[k] = 1'b0; diff_m[k] = '0; bor_m[k] = 1'b0; ovf_m[k] = 1'b0;
         end else if (rem_m[k] > 0) begin
            rem_m[k]--;
            if (rem_m[k] == 0) begin
               done_m[k] = 1'b1;
               diff_m[k] = pdiff[k];
               bor_m[k]  = pbor[k];
               ovf_m[k]  = povf[k];
            end
         end else if (start_v[k]) begin
            int w, t;
            logic [15:0] mask;
            w    = w_of(k);
            mask = 16'((32'd1 << w) - 1);
            t    = int'(a_v[k] & mask) - int'(b_v[k] & mask) - int'(bin_v[k]);
            pdiff[k] = 16'(t) & mask;
            pbor[k]  = (t < 0);
            povf[k]  = (a_v[k][w-1] != b_v[k][w-1]) && (pdiff[k][w-1] != a_v[k][w-1]);
            rem_m[k]  = n_of(k);
            done_m[k] = 1'b0;
         end else begin
            done_m[k] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk("busy",   k, 32'(busy_w[k]), 32'(rem_m[k] > 0));
         chk("done",   k, 32'(done_w[k]), 32'(done_m[k]));
         chk("diff",   k, 32'(act_diff(k)), 32'(diff_m[k]));
         chk("borrow", k, 32'(bor_w[k]), 32'(bor_m[k]));
         chk("ovf",    k, 32'(ovf_w[k]), 32'(ovf_m[k]));
      end
   end

   // One operation; returns the cycle done was seen (start edge = cycle 0) and busy cycles.
   task automatic run_op(int k, logic [15:0] av, logic [15:0] bv, logic bi, bit now,
                         output int cyc, output int bcnt);
      if (!now) @(negedge clk);
      a_v[k] = av; b_v[k] = bv; bin_v[k] = bi; start_v[k] = 1'b1;
      cyc = 0; bcnt = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start_v[k] = 1'b0; a_v[k] = ~av; b_v[k] = ~bv; bin_v[k] = ~bi;
         end
         if (busy_w[k]) bcnt++;
      end while (!done_w[k] && cyc < 64);
      if (!done_w[k]) chk("done_seen", k, 32'(done_w[k]), 32'd1);
   endtask

   int cyc, bc, dn;
   logic [7:0] dtab, btab;
   logic [2:0] ix;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_flags", 0, 32'({busy_w, done_w, bor_w, ovf_w}), 32'd0);
      chk("rst_diff3", 3, 32'(diff3), 32'd0);
      #2 rst_n = 1'b1;

      // T1
      run_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0, cyc, bc);
      chk("t1_cyc", 0, 32'(cyc), 32'd9);
      chk("t1_busy_cycles", 0, 32'(bc), 32'd8);
      chk("t1_diff", 0, 32'(diff0), 32'h1E);
      chk("t1_bor_ovf", 0, 32'({bor_w[0], ovf_w[0]}), 32'd0);

      // T2
      run_op(0, 16'h00, 16'h01, 1'b0, 1'b0, cyc, bc);
      chk("t2a_diff", 0, 32'(diff0), 32'hFF);
      chk("t2a_bor_ovf", 0, 32'({bor_w[0], ovf_w[0]}), 32'b10);
      run_op(0, 16'h80, 16'h01, 1'b0, 1'b0, cyc, bc);
      chk("t2b_diff", 0, 32'(diff0), 32'h7F);
      chk("t2b_bor_ovf", 0, 32'({bor_w[0], ovf_w[0]}), 32'b01);

      // T3: full-subtractor truth table indexed by {a,b,bin}
      dtab = 8'h96;
      btab = 8'h8E;
      for (int i = 0; i < 8; i++) begin
         ix = 3'(i);
         run_op(1, 16'(ix[2]), 16'(ix[1]), ix[0], 1'b0, cyc, bc);
         chk("t3_cyc", 1, 32'(cyc), 32'd2);
         chk("t3_diff", 1, 32'(diff1), 32'(dtab[i]));
         chk("t3_borrow", 1, 32'(bor_w[1]), 32'(btab[i]));
      end

      // T4: back-to-back start in the done cycle
      run_op(2, 16'h10, 16'h01, 1'b1, 1'b0, cyc, bc);
      chk("t4a_cyc", 2, 32'(cyc), 32'd3);
      chk("t4a_diff", 2, 32'(diff2), 32'h0E);
      chk("t4a_borrow", 2, 32'(bor_w[2]), 32'd0);
      run_op(2, 16'h01, 16'h02, 1'b0, 1'b1, cyc, bc);
      chk("t4b_cyc", 2, 32'(cyc), 32'd3);
      chk("t4b_diff", 2, 32'(diff2), 32'hFF);
      chk("t4b_borrow", 2, 32'(bor_w[2]), 32'd1);

      // T5: start while busy is ignored
      @(negedge clk);
      a_v[0] = 16'h5A; b_v[0] = 16'h3C; bin_v[0] = 1'b0; start_v[0] = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start_v[0] = (cyc == 4);
         if (cyc == 4) begin a_v[0] = 16'hFF; b_v[0] = 16'h01; bin_v[0] = 1'b1; end
      end while (!done_w[0] && cyc < 64);
      chk("t5_cyc", 0, 32'(cyc), 32'd9);
      chk("t5_diff", 0, 32'(diff0), 32'h1E);

      // T5: reset in cycle 5 of a new operation
      @(negedge clk);
      a_v[0] = 16'h80; b_v[0] = 16'h01; bin_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_busy_before_rst", 0, 32'(busy_w[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_flags", 0, 32'({busy_w[0], done_w[0], bor_w[0], ovf_w[0]}), 32'd0);
      chk("t5_rst_diff", 0, 32'(diff0), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      dn = 0;
      repeat (15) begin
         @(negedge clk);
         dn += int'(done_w[0]);
      end
      chk("t5_no_done", 0, 32'(dn), 32'd0);

      // T6: random operations, some back-to-back
      for (int i = 0; i < 1000; i++) begin
         bit now;
         now = ($urandom_range(0, 3) == 0);
         if (!now) repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(3, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), now, cyc, bc);
         chk("t6_cyc", 3, 32'(cyc), 32'd9);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
